gpio_debounce: RTL

Input conditioner that sits directly upstream of the GPIO block's input pins: synchronises and debounces WIDTH raw board inputs (buttons, switches) before they reach GPIO ioport bits configured as inputs. Also detects rising and falling edges on the debounced levels and latches them in sticky event bits. The CPU reads and clears these events over the same peripheral bus as GPIO (cs, wr, addr, wdata, rdata), and an irq line signals enabled events.

---
 rtl/gpio_debounce.sv | 132 +++++++++++++
 1 files changed

// File: rtl/gpio_debounce.sv
// Input conditioner for GPIO pins: two-flop synchroniser, per-bit debounce,
// edge pulses, and sticky edge events with enable mask and level interrupt.
module gpio_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  input  logic             cs,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_EDGE   = 2'd1;
  localparam logic [1:0] ADDR_IE     = 2'd2;

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] rise_flags_reg;
  logic [WIDTH-1:0] fall_flags_reg;
  logic [WIDTH-1:0] rise_flags_next;
  logic [WIDTH-1:0] fall_flags_next;
  logic [WIDTH-1:0] ie_rise_reg;
  logic [WIDTH-1:0] ie_fall_reg;
  logic             edge_write;
  logic             ie_write;
  logic             unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], wdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Each channel counts consecutive cycles of disagreement with its clean level.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;
      logic             clean_reg;
      logic             rise_reg;
      logic             fall_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg   <= '0;
          clean_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (sync2_reg[gi] == clean_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            clean_reg <= sync2_reg[gi];
            cnt_reg   <= '0;
            rise_reg  <= sync2_reg[gi];
            fall_reg  <= ~sync2_reg[gi];
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign clean_out[gi]  = clean_reg;
      assign rise_pulse[gi] = rise_reg;
      assign fall_pulse[gi] = fall_reg;
    end
  endgenerate

  assign edge_write = cs & wr & (addr[3:2] == ADDR_EDGE);
  assign ie_write   = cs & wr & (addr[3:2] == ADDR_IE);

  // A pulse arriving alongside a clear keeps the flag set.
  always_comb begin
    rise_flags_next = (rise_flags_reg & ~({WIDTH{edge_write}} & wdata[WIDTH-1:0])) | rise_pulse;
    fall_flags_next = (fall_flags_reg & ~({WIDTH{edge_write}} & wdata[16 +: WIDTH])) | fall_pulse;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_flags_reg <= '0;
      fall_flags_reg <= '0;
      ie_rise_reg    <= '0;
      ie_fall_reg    <= '0;
    end else begin
      rise_flags_reg <= rise_flags_next;
      fall_flags_reg <= fall_flags_next;
      if (ie_write) begin
        ie_rise_reg <= wdata[WIDTH-1:0];
        ie_fall_reg <= wdata[16 +: WIDTH];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      ADDR_STATUS: rdata[WIDTH-1:0] = clean_out;
      ADDR_EDGE: begin
        rdata[WIDTH-1:0]   = rise_flags_reg;
        rdata[16 +: WIDTH] = fall_flags_reg;
      end
      ADDR_IE: begin
        rdata[WIDTH-1:0]   = ie_rise_reg;
        rdata[16 +: WIDTH] = ie_fall_reg;
      end
      default: rdata = '0;
    endcase
  end

  assign irq = |((rise_flags_reg & ie_rise_reg) | (fall_flags_reg & ie_fall_reg));

endmodule
